uart_rx_loader: RTL
===================

Name: uart_rx_loader

Overview:
Serial receive stage that feeds the memory selector during the receive phase. Deserialises 8N1 UART frames from data_from_pc and writes each byte into data memory through the selector's communication port (data_in_com, addr_com, en_com) at consecutive addresses. After a fixed image size it raises end_receiving to main_control.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit (must be even, >= 4)
IMAGE_BYTES, 256, bytes per image load (1..65536)
RX_STATUS, 2'b01, status code meaning "receive phase"

Ports:
clock  input  1  system clock (slowclock output)
reset_n  input  1  asynchronous active-low reset
status  input  2  phase code from main_control
data_from_pc  input  1  UART serial line, idle high, asynchronous
data_in_com  output  8  received byte to the selector
addr_com  output  16  data-memory write address
en_com  output  1  write strobe, one cycle per accepted byte
end_receiving  output  1  image complete; held while status==RX_STATUS
frame_error  output  1  sticky: a byte was dropped for a bad stop bit

Behaviour:
- Reset (async, reset_n low): data_in_com=0, addr_com=0, en_com=0, end_receiving=0, frame_error=0, FSM=IDLE, byte count=0, bit/tick counters=0, synchroniser flops=1.
- data_from_pc passes through a 2-flop synchroniser (rx_s). All decisions use rx_s. Edge-to-detection delay is 2 cycles.
- States: IDLE, START, DATA, STOP, WRITE, DONE.
- IDLE: when status==RX_STATUS and rx_s==0, go to START with tick=0.
- START: count CLKS_PER_BIT/2 ticks to the mid start bit.
  - rx_s==0 at the mid start bit: go to DATA, tick=0, bit=0.
  - rx_s==1: treat as a glitch, return to IDLE with no write.
- DATA: every CLKS_PER_BIT ticks sample rx_s into the shift register, LSB first. After bit 7 go to STOP.
- STOP: after CLKS_PER_BIT ticks sample rx_s.
  - rx_s==1: go to WRITE.
  - rx_s==0: set frame_error (sticky until reset), discard the byte, keep the count, go to IDLE.
- WRITE: lasts exactly one cycle.
  - en_com=1; data_in_com=byte; addr_com=count.
  - Next cycle count increments.
  - If the new count==IMAGE_BYTES, go to DONE; else go to IDLE.
  - data_in_com and addr_com hold their values after the strobe.
- DONE: end_receiving=1. No further frames are accepted.
- When status != RX_STATUS in any state, the next cycle:
  - FSM=IDLE, count=0, end_receiving=0, en_com=0.
  - A partial frame is aborted without a write.
  - frame_error is not cleared.
- addr_com is 16 bits wide. count never exceeds IMAGE_BYTES, so there is no wrap-around. With IMAGE_BYTES=65536 the final write is at 16'hFFFF.
- A new start bit arriving during WRITE is detected in IDLE on the following cycle. The timing slip is at most 1 cycle, well within half a bit.
- Throughput: one byte per frame (10*CLKS_PER_BIT cycles). Back-to-back frames with no idle gap must be accepted.

Test Plan:
1. Reset mid-frame (reset_n low for 1 cycle during DATA) -> all outputs 0 immediately; the next full frame is written at addr 0.
2. CLKS_PER_BIT=16, IMAGE_BYTES=4, status=RX_STATUS, send 0xA5,0x3C,0xFF,0x00 back-to-back ->
   - exactly 4 single-cycle en_com pulses, with (addr,data) = (0,A5),(1,3C),(2,FF),(3,00);
   - end_receiving rises 1 cycle after the 4th strobe and stays high.
3. Low pulse of 5 cycles on data_from_pc -> no en_com, FSM back in IDLE; the next 0x55 frame is written at addr 0.
4. Frame 0x81 with stop bit driven 0 -> no write, frame_error=1; the following 0x42 is written at addr 0 and frame_error stays 1.
5. status leaves RX_STATUS after 2 bytes and mid-third frame, then returns ->
   - no third write;
   - end_receiving=0;
   - the next byte is written at addr 0.
6. End of image: after end_receiving=1, send a 5th frame -> no en_com. Change status -> end_receiving falls 1 cycle later.

Source files
------------

// File: rtl/uart_rx_loader.sv
// 8N1 UART receiver that loads a fixed-size image into data memory through
// the selector's communication port, one write strobe per accepted byte.
module uart_rx_loader #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned IMAGE_BYTES  = 256,
   parameter logic [1:0]  RX_STATUS    = 2'b01
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  status,
   input  logic        data_from_pc,
   output logic [7:0]  data_in_com,
   output logic [15:0] addr_com,
   output logic        en_com,
   output logic        end_receiving,
   output logic        frame_error
);

   localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned CW = $clog2(IMAGE_BYTES + 1);
   localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(IMAGE_BYTES);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWrite, StDone} state_t;

   state_t          r_state, w_state_next;
   logic            r_sync1, r_rx_s;
   logic [TW-1:0]   r_tick, w_tick_next;
   logic [2:0]      r_bit, w_bit_next;
   logic [7:0]      r_shift, w_shift_next;
   logic [CW-1:0]   r_count, w_count_next;
   logic [7:0]      r_data, w_data_next;
   logic [15:0]     r_addr, w_addr_next;
   logic            r_frame_error, w_frame_error_next;
   logic [CW-1:0]   w_count_inc;

   assign w_count_inc = r_count + CW'(1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1       <= 1'b1;
         r_rx_s        <= 1'b1;
         r_state       <= StIdle;
         r_tick        <= '0;
         r_bit         <= '0;
         r_shift       <= '0;
         r_count       <= '0;
         r_data        <= '0;
         r_addr        <= '0;
         r_frame_error <= 1'b0;
      end else begin
         r_sync1       <= data_from_pc;
         r_rx_s        <= r_sync1;
         r_state       <= w_state_next;
         r_tick        <= w_tick_next;
         r_bit         <= w_bit_next;
         r_shift       <= w_shift_next;
         r_count       <= w_count_next;
         r_data        <= w_data_next;
         r_addr        <= w_addr_next;
         r_frame_error <= w_frame_error_next;
      end
   end

   always_comb begin
      w_state_next       = r_state;
      w_tick_next        = r_tick;
      w_bit_next         = r_bit;
      w_shift_next       = r_shift;
      w_count_next       = r_count;
      w_data_next        = r_data;
      w_addr_next        = r_addr;
      w_frame_error_next = r_frame_error;

      // Leaving the receive phase aborts any frame and rewinds the image.
      if (status != RX_STATUS) begin
         w_state_next = StIdle;
         w_count_next = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (!r_rx_s) begin
                  w_state_next = StStart;
                  w_tick_next  = '0;
               end
            end
            StStart: begin
               if (r_tick == TICK_HALF) begin
                  w_tick_next  = '0;
                  w_bit_next   = '0;
                  w_state_next = r_rx_s ? StIdle : StData;
               end else begin
                  w_tick_next = r_tick + TW'(1);
               end
            end
            StData: begin
               if (r_tick == TICK_FULL) begin
                  w_tick_next  = '0;
                  w_shift_next = {r_rx_s, r_shift[7:1]};
                  w_bit_next   = r_bit + 3'd1;
                  if (r_bit == 3'd7) w_state_next = StStop;
               end else begin
                  w_tick_next = r_tick + TW'(1);
               end
            end
            StStop: begin
               if (r_tick == TICK_FULL) begin
                  w_tick_next = '0;
                  if (r_rx_s) begin
                     w_state_next = StWrite;
                     w_data_next  = r_shift;
                     w_addr_next  = 16'(r_count);
                  end else begin
                     w_frame_error_next = 1'b1;
                     w_state_next       = StIdle;
                  end
               end else begin
                  w_tick_next = r_tick + TW'(1);
               end
            end
            StWrite: begin
               w_count_next = w_count_inc;
               w_state_next = (w_count_inc == COUNT_MAX) ? StDone : StIdle;
            end
            StDone: ;
            default: w_state_next = StIdle;
         endcase
      end
   end

   assign data_in_com   = r_data;
   assign addr_com      = r_addr;
   assign en_com        = (r_state == StWrite);
   assign end_receiving = (r_state == StDone);
   assign frame_error   = r_frame_error;

endmodule
